sysid_rom_reader: RTL

AXI4-Lite master that autonomously dumps the system-ID ROM of an adjacent system-ID register slave onto an AXI4-Stream. On a start pulse it checks the slave's magic word, writes the ROM address pointer, then reads the auto-incrementing ROM data register WORD_COUNT times, forwarding each word downstream. It sits directly upstream of the slave's AXI-Lite port, or behind an interconnect. Its stream feeds a UART or boot-log formatter.

---
 rtl/sysid_rom_reader.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sysid_rom_reader.sv
// AXI4-Lite master that verifies the system-ID magic word, sets the ROM pointer,
// then streams WORD_COUNT auto-incremented ROM words out on AXI4-Stream.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where valid and ready are both high; valid, once raised, holds its payload
// stable until that edge and drops on the following cycle.
module sysid_rom_reader #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int unsigned START_WORD = 0,
    parameter int unsigned WORD_COUNT = 64
) (
    input  logic        m_axi_aclk,
    input  logic        m_axi_aresetn,

    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,

    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [15:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic [1:0]  m_axi_bresp,

    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [15:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,

    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,

    output logic [3:0]  dbg_state_o
);

    localparam logic [31:0] MAGIC_VALUE   = 32'h5359_4944;
    localparam logic [15:0] MAGIC_ADDR    = BASE_ADDR + 16'h000C;
    localparam logic [15:0] ROM_DATA_ADDR = BASE_ADDR + 16'h0084;
    localparam logic [15:0] ROM_ADDR_ADDR = BASE_ADDR + 16'h0088;
    localparam logic [31:0] START_VALUE   = 32'(START_WORD);
    localparam logic [10:0] LAST_IDX      = 11'(WORD_COUNT - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_MAG_AR  = 4'd1,
        S_MAG_R   = 4'd2,
        S_ADDR_AW = 4'd3,
        S_ADDR_B  = 4'd4,
        S_ROM_AR  = 4'd5,
        S_ROM_R   = 4'd6,
        S_STREAM  = 4'd7,
        S_FINISH  = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        arvalid_q, arvalid_d;
    logic [15:0] araddr_q, araddr_d;
    logic        awvalid_q, awvalid_d;
    logic [15:0] awaddr_q, awaddr_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;

    logic aw_fin, w_fin;

    // A write sub-channel is finished once its valid is already down or is being accepted now.
    assign aw_fin = !awvalid_q || m_axi_awready;
    assign w_fin  = !wvalid_q  || m_axi_wready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    arvalid_d = 1'b1;
                    araddr_d  = MAGIC_ADDR;
                    state_d   = S_MAG_AR;
                end
            end
            S_MAG_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_MAG_R;
                end
            end
            S_MAG_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00 || m_axi_rdata != MAGIC_VALUE) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        awvalid_d = 1'b1;
                        awaddr_d  = ROM_ADDR_ADDR;
                        wvalid_d  = 1'b1;
                        wdata_d   = START_VALUE;
                        state_d   = S_ADDR_AW;
                    end
                end
            end
            S_ADDR_AW: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_fin && w_fin)            state_d   = S_ADDR_B;
            end
            S_ADDR_B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = ROM_DATA_ADDR;
                        state_d   = S_ROM_AR;
                    end
                end
            end
            S_ROM_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_ROM_R;
                end
            end
            S_ROM_R: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        tdata_d  = m_axi_rdata;
                        tvalid_d = 1'b1;
                        tlast_d  = (cnt_q == LAST_IDX);
                        state_d  = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                // The slave pointer advances on every read, so the next read waits for this beat.
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    cnt_d    = cnt_q + 11'd1;
                    if (tlast_q) begin
                        state_d = S_FINISH;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = ROM_DATA_ADDR;
                        state_d   = S_ROM_AR;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = (state_q == S_ADDR_B);

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (state_q == S_MAG_R) || (state_q == S_ROM_R);

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;

    assign dbg_state_o   = state_q;

endmodule
